// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
//   state_t     FSM state encodings
//   req_id_t    requester identifiers (instruction fetch / load-store)
//   W_*         mem_width codes (2'b11 behaves as a word)
//   beat_count  number of byte beats for a width code
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam int CNT_W = 3;

  function automatic logic [CNT_W-1:0] beat_count(input logic [1:0] width);
    case (width)
      W_BYTE:  return 3'd1;
      W_HALF:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_word_pack.sv
// Combinational byte-lane helper for the memory arbiter.
// Ports:
//   width      latched access width code
//   lane       byte lane of the current beat
//   wdata      latched store word
//   rbuf       partially assembled load word
//   din        byte returned by memory
//   beats      number of beats for width (1/2/4)
//   store_byte byte of wdata on the selected lane
//   load_word  rbuf with din inserted on the selected lane
module mem_arbiter_word_pack
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]       width,
  input  logic [1:0]       lane,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rbuf,
  input  logic [7:0]       din,
  output logic [CNT_W-1:0] beats,
  output logic [7:0]       store_byte,
  output logic [31:0]      load_word
);

  always_comb begin
    beats      = beat_count(width);
    store_byte = wdata[7:0];
    load_word  = rbuf;
    case (lane)
      2'd0: begin
        store_byte      = wdata[7:0];
        load_word[7:0]  = din;
      end
      2'd1: begin
        store_byte      = wdata[15:8];
        load_word[15:8] = din;
      end
      2'd2: begin
        store_byte       = wdata[23:16];
        load_word[23:16] = din;
      end
      default: begin
        store_byte       = wdata[31:24];
        load_word[31:24] = din;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one byte-wide synchronous RAM port between instruction
// fetch (IF) and load/store (MEM). Splits stores into byte beats and
// assembles loads little-endian, zero-extended to 32 bits.
//
// Build option: define ARB_RR_EN for round-robin arbitration between the
// two requesters; otherwise MEM has fixed priority over IF.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   if_req/if_addr           fetch request (always a word)
//   if_ack/if_rdata          one-cycle completion pulse and fetched word
//   mem_req/we/width/addr/wdata  load/store request and attributes
//   mem_ack/mem_rdata        one-cycle completion pulse and load data
//   bus_addr/we/dout/din     byte RAM port (read data one cycle after address)
//   busy                     FSM not idle
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request; grant and latch happen at this edge
// ST_WR   | one store byte per cycle, cnt = byte index
// ST_RD   | address byte cnt, capture byte cnt-1 (one extra cycle)
// ST_DONE | ack to the granted requester, requests ignored
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_width,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [7:0]        bus_dout,
  input  logic [7:0]        bus_din,
  output logic              busy
);

  state_t            state, state_nxt;
  req_id_t           id;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        width;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  beats;
  logic [1:0]        lane;
  logic [7:0]        store_byte;
  logic [31:0]       load_word;
  logic              prefer_mem;
  logic              grant_mem;
  logic              grant_if;

  // Only the low ADDR_W address bits reach the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

`ifdef ARB_RR_EN
  req_id_t last_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= REQ_IF;
    end else if (grant_mem || grant_if) begin
      last_grant <= grant_mem ? REQ_MEM : REQ_IF;
    end
  end

  assign prefer_mem = (last_grant == REQ_IF);
`else
  assign prefer_mem = 1'b1;
`endif

  assign grant_mem = (state == ST_IDLE) && mem_req && (prefer_mem || !if_req);
  assign grant_if  = (state == ST_IDLE) && if_req && !grant_mem;

  // Read data for the byte addressed at cnt-1 arrives while cnt is shown.
  assign lane = (state == ST_RD) ? (cnt[1:0] - 2'd1) : cnt[1:0];

  mem_arbiter_word_pack u_pack (
    .width      (width),
    .lane       (lane),
    .wdata      (wdata),
    .rbuf       (rbuf),
    .din        (bus_din),
    .beats      (beats),
    .store_byte (store_byte),
    .load_word  (load_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      id        <= REQ_IF;
      addr      <= '0;
      width     <= W_WORD;
      wdata     <= '0;
      rbuf      <= '0;
      cnt       <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (grant_mem || grant_if) begin
            id    <= grant_mem ? REQ_MEM : REQ_IF;
            addr  <= grant_mem ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
            width <= grant_mem ? mem_width : W_WORD;
            wdata <= mem_wdata;
            rbuf  <= '0;
            cnt   <= '0;
          end
        end
        ST_WR: cnt <= cnt + 3'd1;
        ST_RD: begin
          cnt <= cnt + 3'd1;
          if (cnt != '0) rbuf <= load_word;
          if (cnt == beats) begin
            if (id == REQ_MEM) mem_rdata <= load_word;
            else               if_rdata  <= load_word;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_dout  = '0;
    if_ack    = 1'b0;
    mem_ack   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_mem)     state_nxt = mem_we ? ST_WR : ST_RD;
        else if (grant_if) state_nxt = ST_RD;
      end
      ST_WR: begin
        bus_we   = 1'b1;
        bus_addr = addr + ADDR_W'(cnt);
        bus_dout = store_byte;
        if (cnt == beats - 3'd1) state_nxt = ST_DONE;
      end
      ST_RD: begin
        if (cnt != beats) bus_addr = addr + ADDR_W'(cnt);
        else              state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if_ack    = (id == REQ_IF);
        mem_ack   = (id == REQ_MEM);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model on the bus, scoreboard queues of
// expected read data per port, and a log of bus writes.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 17;
`ifdef ARB_RR_EN
  localparam int EXP_RR_FIRST = 2;
`else
  localparam int EXP_RR_FIRST = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [1:0]        mem_width = 2'b00;
  logic [31:0]       mem_addr = '0;
  logic [31:0]       mem_wdata = '0;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [7:0]        bus_dout;
  logic [7:0]        bus_din;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [32:0] exp_if_q[$];
  logic [32:0] exp_mem_q[$];
  logic [32:0] e_if, e_mem;

  typedef struct {
    int               cyc;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } wr_t;
  wr_t wlog[$];

  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]        pre_data = '0;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_width (mem_width),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_dout  (bus_dout),
    .bus_din   (bus_din),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (pre_we)      ram[pre_addr] <= pre_data;
    else if (bus_we) ram[bus_addr] <= bus_dout;
    bus_din <= ram[bus_addr];
  end

  always @(negedge clk) begin
    if (rst && bus_we) wlog.push_back('{cyc: cyc_cnt, a: bus_addr, d: bus_dout});
  end

  // Scoreboard: each ack pops the expectation queued when its request was driven.
  always @(negedge clk) begin
    if (rst && if_ack) begin
      checks++;
      if (exp_if_q.size() == 0) begin
        errors++;
        $display("FAIL if_ack_unexpected: if_ack=1 with no fetch outstanding");
      end else begin
        e_if = exp_if_q.pop_front();
        if (if_rdata !== e_if[31:0]) begin
          errors++;
          $display("FAIL if_rdata: got %h want %h", if_rdata, e_if[31:0]);
        end
      end
    end
    if (rst && mem_ack) begin
      checks++;
      if (exp_mem_q.size() == 0) begin
        errors++;
        $display("FAIL mem_ack_unexpected: mem_ack=1 with no access outstanding");
      end else begin
        e_mem = exp_mem_q.pop_front();
        if (e_mem[32] && mem_rdata !== e_mem[31:0]) begin
          errors++;
          $display("FAIL mem_rdata: got %h want %h", mem_rdata, e_mem[31:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic preload;
    poke(17'h00000, 8'hEF); poke(17'h00001, 8'hBE);
    poke(17'h00002, 8'hAD); poke(17'h00003, 8'hDE);
    poke(17'h00100, 8'h11); poke(17'h00101, 8'h22);
    poke(17'h00102, 8'h33); poke(17'h00103, 8'h44);
    for (int i = 0; i < 4; i++) poke(17'h00300 + 17'(i), 8'h77);
    for (int i = 0; i < 8; i++) poke(17'h00400 + 17'(i), 8'(i + 1));
    poke(17'h1FFFF, 8'h99);
  endtask

  // Drives one load/store and waits for its ack; lat counts negedges from drive.
  task automatic mem_access(input logic we, input logic [1:0] w, input logic [31:0] a,
                            input logic [31:0] d, output int lat);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_width = w; mem_addr = a; mem_wdata = d;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (mem_ack) begin
        lat = c;
        break;
      end
    end
    mem_req = 1'b0;
    mem_we  = 1'b0;
  endtask

  // Raises a word fetch of 0x0 and a word load of 0x100 together; first = 1 MEM, 2 IF.
  task automatic pair_access(output int first, output int both_done);
    int dm, di;
    first = 0; dm = 0; di = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    mem_req = 1'b1; mem_we = 1'b0; mem_width = W_WORD; mem_addr = 32'h100;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (mem_ack) begin
        if (first == 0) first = 1;
        mem_req = 1'b0;
        dm = 1;
      end
      if (if_ack) begin
        if (first == 0) first = 2;
        if_req = 1'b0;
        di = 1;
      end
      if (dm != 0 && di != 0) break;
    end
    both_done = (dm != 0 && di != 0) ? 1 : 0;
    if_req = 1'b0;
    mem_req = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({if_ack, mem_ack, bus_we, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {if_ack, mem_ack, bus_we, busy});
    end
    checks++;
    if ({if_rdata, mem_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h %h want 0", if_rdata, mem_rdata);
    end
    checks++;
    if (bus_addr !== '0 || bus_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: got addr %h dout %h want 0", bus_addr, bus_dout);
    end
    rst = 1'b1;
  endtask

  task automatic test_word_load;
    int lat;
    exp_mem_q.push_back({1'b1, 32'h44332211});
    mem_access(1'b0, W_WORD, 32'h100, 32'h0, lat);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL word_load_latency: got %0d want 6", lat);
    end
    @(negedge clk);
    checks++;
    if (mem_ack !== 1'b0) begin
      errors++;
      $display("FAIL word_load_ack_width: mem_ack got %b want 0", mem_ack);
    end
    checks++;
    if (mem_rdata !== 32'h44332211) begin
      errors++;
      $display("FAIL word_load_hold: got %h want 44332211", mem_rdata);
    end
  endtask

  task automatic test_word_store;
    int lat;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
    wlog.delete();
    exp_mem_q.push_back({1'b0, 32'h0});
    mem_access(1'b1, W_WORD, 32'h200, 32'hA1B2C3D4, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL word_store_latency: got %0d want 5", lat);
    end
    checks++;
    if (wlog.size() != 4) begin
      errors++;
      $display("FAIL word_store_beats: got %0d want 4", wlog.size());
    end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i].a !== 17'h00200 + 17'(i) || wlog[i].d !== exp_b[i] || wlog[i].cyc != wlog[0].cyc + i) begin
        errors++;
        $display("FAIL word_store_beat%0d: got addr %h data %h cyc %0d want addr %h data %h cyc %0d",
                 i, wlog[i].a, wlog[i].d, wlog[i].cyc, 17'h00200 + 17'(i), exp_b[i], wlog[0].cyc + i);
      end
    end
    exp_mem_q.push_back({1'b1, 32'hA1B2C3D4});
    mem_access(1'b0, W_WORD, 32'h200, 32'h0, lat);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL word_store_readback_latency: got %0d want 6", lat);
    end
  endtask

  task automatic test_half_load;
    int lat;
    exp_mem_q.push_back({1'b1, 32'h00004433});
    mem_access(1'b0, W_HALF, 32'h102, 32'h0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL half_load_latency: got %0d want 4", lat);
    end
  endtask

  task automatic test_byte_store_top;
    int lat;
    wlog.delete();
    exp_mem_q.push_back({1'b0, 32'h0});
    mem_access(1'b1, W_BYTE, 32'h0001FFFF, 32'hFFFFFF5A, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL byte_store_latency: got %0d want 2", lat);
    end
    checks++;
    if (wlog.size() != 1 || wlog[0].a !== 17'h1FFFF || wlog[0].d !== 8'h5A) begin
      errors++;
      $display("FAIL byte_store_beat: got %0d beats first addr %h data %h want 1 beat addr 1ffff data 5a",
               wlog.size(), (wlog.size() > 0) ? wlog[0].a : 17'h0, (wlog.size() > 0) ? wlog[0].d : 8'h0);
    end
    checks++;
    if (ram[17'h1FFFF] !== 8'h5A || ram[17'h00000] !== 8'hEF) begin
      errors++;
      $display("FAIL byte_store_ram: got top %h bottom %h want 5a ef", ram[17'h1FFFF], ram[17'h00000]);
    end
    exp_mem_q.push_back({1'b1, 32'h0000005A});
    mem_access(1'b0, W_BYTE, 32'h1FFFF, 32'h0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL byte_load_latency: got %0d want 3", lat);
    end
  endtask

  task automatic test_arbitration;
    int first, done;
    exp_if_q.push_back({1'b1, 32'hDEADBEEF});
    exp_mem_q.push_back({1'b1, 32'h44332211});
    pair_access(first, done);
    checks++;
    if (done != 1) begin
      errors++;
      $display("FAIL arb_pair_done: got %0d want 1", done);
    end
    checks++;
    if (first != 1) begin
      errors++;
      $display("FAIL arb_first: got %0d want 1 (MEM)", first);
    end
  endtask

  task automatic test_round_robin;
    int first, done, lat;
    exp_mem_q.push_back({1'b1, 32'h44332211});
    mem_access(1'b0, W_WORD, 32'h100, 32'h0, lat);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL rr_single_latency: got %0d want 6", lat);
    end
    exp_if_q.push_back({1'b1, 32'hDEADBEEF});
    exp_mem_q.push_back({1'b1, 32'h44332211});
    pair_access(first, done);
    checks++;
    if (done != 1) begin
      errors++;
      $display("FAIL rr_pair_done: got %0d want 1", done);
    end
    checks++;
    if (first != EXP_RR_FIRST) begin
      errors++;
      $display("FAIL rr_first: got %0d want %0d", first, EXP_RR_FIRST);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_width = W_WORD;
    mem_addr = 32'h300; mem_wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({if_ack, mem_ack, bus_we, busy} !== 4'b0 || bus_addr !== '0 || bus_dout !== 8'h00) begin
      errors++;
      $display("FAIL abort_outputs: flags %b addr %h dout %h want 0",
               {if_ack, mem_ack, bus_we, busy}, bus_addr, bus_dout);
    end
    checks++;
    if ({if_rdata, mem_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL abort_rdata: got %h %h want 0", if_rdata, mem_rdata);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]} !== 32'h7777F00D) begin
      errors++;
      $display("FAIL abort_ram: got %h want 7777f00d",
               {ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]});
    end
    rst = 1'b1;
    exp_mem_q.push_back({1'b1, 32'h7777F00D});
    mem_access(1'b0, W_WORD, 32'h300, 32'h0, lat);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL abort_fresh_latency: got %0d want 6", lat);
    end
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    c1 = -1; c2 = -1;
    exp_if_q.push_back({1'b1, 32'h04030201});
    exp_if_q.push_back({1'b1, 32'h08070605});
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h400;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (if_ack) begin
        if (c1 < 0) begin
          c1 = c;
          if_addr = 32'h404;
        end else begin
          c2 = c;
          break;
        end
      end
    end
    if_req = 1'b0;
    checks++;
    if (c1 != 6) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d want 6", c1);
    end
    checks++;
    if (c2 < 0 || c2 - c1 != 7) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want 7", (c2 < 0) ? -1 : c2 - c1);
    end
  endtask

  initial begin
    preload();
    test_reset();
    test_word_load();
    test_word_store();
    test_half_load();
    test_byte_store_top();
    test_arbitration();
    test_round_robin();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_if_q.size() != 0 || exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: if %0d mem %0d left want 0 0", exp_if_q.size(), exp_mem_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
